if_id_pipe: RTL

IF_ID_PIPE -- requirements
Module: if_id_pipe

---
 rtl/mips_pkg.sv | 14 +
 rtl/pipe_entry.sv | 27 ++
 rtl/if_id_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline-register types: occupancy states and the default bubble instruction.
package mips_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot with a valid bit; clear wins over load and zeroes the payload.
module pipe_entry #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with valid/ready handshake, stall bubbles, flush and stall counter.
// Define IF_ID_SKID_EN to add a skid slot so in_ready no longer depends on out_ready.
module if_id_pipe
    import mips_pkg::*;
#(
    parameter int unsigned        PC_W     = 32,
    parameter int unsigned        INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INST_W-1:0]      in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INST_W-1:0]      out_inst,
    input  logic                   stall,
    input  logic                   flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int unsigned W = PC_W + INST_W;

    pipe_state_e    state_q, state_d;
    logic           main_load, main_clear, main_valid;
    logic [W-1:0]   main_d, main_q;
    logic           in_xfer, out_xfer;

    assign out_valid = main_valid & ~stall;
    assign out_pc    = out_valid ? main_q[W-1:INST_W] : '0;
    assign out_inst  = out_valid ? main_q[INST_W-1:0] : NOP_INST;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

`ifdef IF_ID_SKID_EN
    logic           skid_load, skid_clear, skid_valid, main_sel_skid;
    logic [W-1:0]   skid_q;

    // Readiness comes from skid occupancy only, never from out_ready.
    assign in_ready = rst_n & ~stall & (flush | ~skid_valid);
    assign main_d   = main_sel_skid ? skid_q : {in_pc, in_inst};

    pipe_entry #(.W(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_pc, in_inst}),
        .valid (skid_valid),
        .q     (skid_q)
    );
`else
    assign in_ready = rst_n & ~stall & (~main_valid | out_ready | flush);
    assign main_d   = {in_pc, in_inst};
`endif

    pipe_entry #(.W(W)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy transitions; flush beats stall, stall freezes everything.
    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef IF_ID_SKID_EN
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        main_sel_skid = 1'b0;
`endif
        if (flush) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
`ifdef IF_ID_SKID_EN
            skid_clear = 1'b1;
`endif
        end else if (!stall) begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
`ifdef IF_ID_SKID_EN
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = SKID;
`endif
                    end else if (out_xfer) begin
                        main_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
`ifdef IF_ID_SKID_EN
                SKID: begin
                    if (out_xfer) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                        state_d       = FULL;
                    end
                end
`endif
                default: begin
                    state_d    = EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
